// File: rtl/seq_div32x16.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per cycle.
// Optional early overflow/divide-by-zero detection is enabled by defining DIV_OVF_CHECK_EN.
module seq_div32x16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     Rm,
    output logic                 ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    // Low dividend half shifts out MSB-first while quotient bits shift in at the LSB.
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rm_q, rm_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   trial_s;
    logic             ge_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] lo_step_s;

    // One restoring step: shift in the next dividend bit, subtract the divisor when it fits.
    always_comb begin
        trial_s    = {rem_q, lo_q[WIDTH-1]};
        ge_s       = (trial_s >= {1'b0, b_q});
        diff_s     = trial_s[WIDTH-1:0] - b_q;
        rem_step_s = ge_s ? diff_s : trial_s[WIDTH-1:0];
        lo_step_s  = {lo_q[WIDTH-2:0], ge_s};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        b_d         = b_q;
        q_d         = q_q;
        rm_d        = rm_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_d   = A[2*WIDTH-1:WIDTH];
                    lo_d    = A[WIDTH-1:0];
                    b_d     = B;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
`ifdef DIV_OVF_CHECK_EN
                    // High half >= divisor means the quotient cannot fit; also covers B == 0.
                    if (A[2*WIDTH-1:WIDTH] >= B) begin
                        state_d = ST_DONE;
                        q_d     = '1;
                        rm_d    = '1;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                rem_d = rem_step_s;
                lo_d  = lo_step_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    q_d     = lo_step_s;
                    rm_d    = rem_step_s;
                    ovf_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            q_q         <= '0;
            rm_q        <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            q_q         <= q_d;
            rm_q        <= rm_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign Rm        = rm_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_div32x16.sv
// Directed and random checks for seq_div32x16; overflow cases run when DIV_OVF_CHECK_EN is defined.
module tb_seq_div32x16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Q;
    logic [15:0] Rm;
    logic        ovf;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] rm;
    } vec_t;

    seq_div32x16 #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .Rm(Rm), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; returns at a negedge after the result handshake.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int pre_gap,
                          input int rdy_gap, output logic [15:0] q, output logic [15:0] rm,
                          output logic ov, output int lat);
        int budget;
        q = '0; rm = '0; ov = 1'b0; lat = -1;
        for (int i = 0; i < pre_gap; i++) @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        budget = 0;
        while (!in_ready && budget < 100) begin @(negedge clk); budget++; end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!out_valid) begin
            check("result_timeout", 64'd0, 64'd1);
            lat = -1;
            return;
        end
        q = Q; rm = Rm; ov = ovf;
        for (int i = 0; i < rdy_gap; i++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after_done", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [15:0] q, rm;
        logic        ov;
        int          lat;
        logic        seen;
        logic [15:0] hi, lo, rb;
        logic [31:0] ra;
        int          rand_bad;

        vecs[0] = '{32'd100,        16'd7,      16'd14,     16'd2};
        vecs[1] = '{32'hFFFE_0001,  16'hFFFF,   16'hFFFF,   16'h0000};
        vecs[2] = '{32'h0001_0000,  16'd3,      16'h5555,   16'h0001};
        vecs[3] = '{32'd9,          16'd2,      16'd4,      16'd1};
        vecs[4] = '{32'd0,          16'd5,      16'd0,      16'd0};
        vecs[5] = '{32'hFFFE_FFFF,  16'hFFFF,   16'hFFFF,   16'hFFFE};
        vecs[6] = '{32'h0000_FFFF,  16'd1,      16'hFFFF,   16'h0000};
        vecs[7] = '{32'd1000000,    16'd256,    16'd3906,   16'd64};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_q",         {48'd0, Q},         64'd0);
        check("rst_rm",        {48'd0, Rm},        64'd0);
        check("rst_ovf",       {63'd0, ovf},       64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, i % 2, i % 3, q, rm, ov, lat);
            check($sformatf("vec%0d_q", i),   {48'd0, q},  {48'd0, vecs[i].q});
            check($sformatf("vec%0d_rm", i),  {48'd0, rm}, {48'd0, vecs[i].rm});
            check($sformatf("vec%0d_ovf", i), {63'd0, ov}, 64'd0);
            check($sformatf("vec%0d_lat", i), 64'(lat),    64'd17);
        end

        // Hold the result with out_ready low while a competing operand is offered.
        A = 32'h0001_0000; B = 16'd3; in_valid = 1'b1;
        @(negedge clk);
        A = 32'd50; B = 16'd5;
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        check("hold_lat", 64'(lat), 64'd17);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_q",     {48'd0, Q},         64'h5555);
            check("hold_rm",    {48'd0, Rm},        64'd1);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_ready", {63'd0, in_ready},  64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_exit_valid", {63'd0, out_valid}, 64'd0);
        check("hold_exit_ready", {63'd0, in_ready},  64'd1);
        repeat (20) @(negedge clk);
        check("hold_no_capture", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of an operation abandons it.
        A = 32'd100; B = 16'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        check("abort_in_ready",  {63'd0, in_ready},  64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", {63'd0, seen}, 64'd0);
        run_op(32'd9, 16'd2, 0, 0, q, rm, ov, lat);
        check("abort_next_q",  {48'd0, q},  64'd4);
        check("abort_next_rm", {48'd0, rm}, 64'd1);

`ifdef DIV_OVF_CHECK_EN
        run_op(32'd5, 16'd0, 0, 1, q, rm, ov, lat);
        check("dz_lat", 64'(lat),    64'd1);
        check("dz_ovf", {63'd0, ov}, 64'd1);
        check("dz_q",   {48'd0, q},  64'hFFFF);
        check("dz_rm",  {48'd0, rm}, 64'hFFFF);
        run_op(32'h0007_0000, 16'd7, 1, 0, q, rm, ov, lat);
        check("ovf_lat", 64'(lat),    64'd1);
        check("ovf_ovf", {63'd0, ov}, 64'd1);
        run_op(32'h0006_FFFF, 16'd7, 0, 0, q, rm, ov, lat);
        check("edge_ovf", {63'd0, ov}, 64'd0);
        check("edge_q",   {48'd0, q},  64'hFFFF);
        check("edge_rm",  {48'd0, rm}, 64'd6);
`endif

        rand_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            rb = 16'($urandom_range(1, 65535));
            hi = 16'($urandom % {16'd0, rb});
            lo = 16'($urandom);
            ra = {hi, lo};
            run_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), q, rm, ov, lat);
            total++;
            if ((32'(q) * 32'(rb) + 32'(rm) == ra) && (rm < rb) && !ov && lat == 17) begin
                passed++;
            end else begin
                rand_bad++;
                if (rand_bad < 10)
                    $display("FAIL rand%0d: A=0x%0h B=0x%0h got Q=0x%0h Rm=0x%0h ovf=%0d lat=%0d",
                             i, ra, rb, q, rm, ov, lat);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_div32x16.md
SEQ_DIV32X16 -- requirements
Module: seq_div32x16

Interface
REQ-001 SHALL have parameter WIDTH, default 16: divisor, quotient and remainder width; dividend is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: operands A/B valid.
REQ-005 SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 SHALL have port A, input, 2*WIDTH: unsigned dividend, i.e. the multiplier product format.
REQ-007 SHALL have port B, input, WIDTH: unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1: Q/Rm/ovf valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port Q, output, WIDTH: quotient.
REQ-011 SHALL have port Rm, output, WIDTH: remainder.
REQ-012 SHALL have port ovf, output, 1: quotient does not fit in WIDTH bits, or B==0.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept an operation when in_valid&&in_ready is sampled high at an edge: capture A and B, and enter BUSY with iteration counter = 0.
REQ-015 SHALL, in BUSY, perform one restoring-division step per cycle, MSB first.
  - Step: shift the (WIDTH+1)-bit partial remainder left, bringing in the next dividend bit.
  - If the partial remainder >= B, subtract B and set the quotient bit to 1.
REQ-016 SHALL run exactly WIDTH BUSY cycles, then enter DONE; out_valid rises WIDTH+1 cycles after the accept edge (17 for default WIDTH).
REQ-017 SHALL, for non-overflow inputs, produce Q = floor(A/B) and Rm = A mod B, with Q*B+Rm == A and Rm < B.
REQ-018 SHALL hold Q, Rm and ovf stable in DONE until out_valid&&out_ready; on that edge, return to IDLE.
REQ-019 SHALL ignore in_valid while in BUSY or DONE; no operand is captured and none is lost, because in_ready is low.
REQ-020 SHALL allow back-to-back operation: the next accept can occur one cycle after DONE exits, i.e. a minimum period of WIDTH+2 cycles.
REQ-021 SHALL treat out_ready as don't-care outside DONE.
REQ-022 SHALL keep Q/Rm/ovf stable whenever out_valid is high; their values are don't-care when out_valid is low.

Reset
REQ-023 SHALL, while rst is high at an edge, force state=IDLE, counter=0, Q=0, Rm=0, ovf=0, out_valid=0 and in_ready=1 after that edge.
REQ-024 SHALL, on reset during BUSY or DONE, abandon the operation; no out_valid pulse follows.
REQ-025 SHALL give rst priority over a simultaneous in_valid accept or out_ready handshake.

Configuration
REQ-026 SHALL support macro DIV_OVF_CHECK_EN.
  - Defined: at accept, if A[2*WIDTH-1:WIDTH] >= B (this includes B==0), skip BUSY and enter DONE on the next edge with Q=all ones, Rm=all ones, ovf=1; out_valid rises 1 cycle after the accept edge.
  - Not defined: ovf is tied 0; every operation takes WIDTH BUSY cycles; Q/Rm are unspecified for overflow inputs.
  - Non-overflow behaviour SHALL be identical with and without the macro.

Verification
REQ-027 SHALL cover: A=100, B=7 -> Q=14, Rm=2, ovf=0, out_valid 17 cycles after the accept.
REQ-028 SHALL cover: A=0xFFFE0001, B=0xFFFF -> Q=0xFFFF, Rm=0, ovf=0 (inverse of the 0xFFFF*0xFFFF product).
REQ-029 SHALL cover: A=0x00010000, B=3 -> Q=0x5555, Rm=1; hold out_ready low for 5 cycles -> Q/Rm/out_valid stay constant and in_ready stays 0.
REQ-030 SHALL cover, with DIV_OVF_CHECK_EN: A=5, B=0 -> out_valid 1 cycle after the accept, ovf=1, Q=0xFFFF, Rm=0xFFFF; A=0x00070000, B=7 -> ovf=1.
REQ-031 SHALL cover: assert rst at BUSY cycle 8 -> next cycle in_ready=1 and out_valid=0, and no result ever appears; a new A=9, B=2 then gives Q=4, Rm=1.
REQ-032 SHALL cover 1000 random non-overflow pairs with random in_valid/out_ready gaps, checked against Q*B+Rm==A and Rm<B.
